// File: rtl/uart_rx_fifo.sv
// Receive-side frame buffer behind the UART receiver.
// Captures {stop_err, parity_err, p_data} on each rising edge of valid_data into a
// circular FIFO, and offers a registered pop port plus occupancy, overflow and error-count status.
module uart_rx_fifo #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter bit          DROP_ERR = 1'b0
) (
    input  logic              clk2,
    input  logic              rst,
    input  logic [7:0]        p_data,
    input  logic              valid_data,
    input  logic              parity_err,
    input  logic              stop_err,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              rd_perr,
    output logic              rd_serr,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              ovf,
    input  logic              ovf_clr,
    output logic [7:0]        err_cnt
);

    localparam logic [ADDR_W:0]   CntOne  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CntFull = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PtrOne  = ADDR_W'(1);

    logic [9:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              valid_q;
    logic              ovf_q, ovf_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [9:0]        rd_entry_q, rd_entry_d;
    logic              rd_valid_q;

    logic cap, ferr, wr, rd_acc, wr_acc, empty_w, full_w;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CntFull);

    // Capture/accept decode and next-state for pointers, occupancy and status.
    always_comb begin
        cap    = valid_data & ~valid_q;
        ferr   = parity_err | stop_err;
        wr     = cap & ~(DROP_ERR & ferr);
        rd_acc = rd_en & ~empty_w;
        // A read in the same cycle frees a slot, so a full FIFO can still take the write.
        wr_acc = wr & (~full_w | rd_acc);

        wr_ptr_d   = wr_acc ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d   = rd_acc ? rd_ptr_q + PtrOne : rd_ptr_q;
        rd_entry_d = rd_acc ? mem_q[rd_ptr_q] : rd_entry_q;

        count_d = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase

        // Set has priority over clear.
        ovf_d = ovf_q;
        if (wr & ~wr_acc) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end

        err_cnt_d = err_cnt_q;
        if (cap & ferr & (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Control and status state.
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            err_cnt_q  <= '0;
            rd_entry_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_data;
            ovf_q      <= ovf_d;
            err_cnt_q  <= err_cnt_d;
            rd_entry_q <= rd_entry_d;
            rd_valid_q <= rd_acc;
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk2) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= {stop_err, parity_err, p_data};
        end
    end

    assign rd_data  = rd_entry_q[7:0];
    assign rd_perr  = rd_entry_q[8];
    assign rd_serr  = rd_entry_q[9];
    assign rd_valid = rd_valid_q;
    assign empty    = empty_w;
    assign full     = full_w;
    assign count    = count_q;
    assign ovf      = ovf_q;
    assign err_cnt  = err_cnt_q;

endmodule
